// File: rtl/sync_debounce_pkg.sv
// sync_debounce_pkg: shared FSM state encodings for the sync_debounce slice
package sync_debounce_pkg;
   localparam logic [1:0] LOW      = 2'd0;
   localparam logic [1:0] CHK_HIGH = 2'd1;
   localparam logic [1:0] HIGH     = 2'd2;
   localparam logic [1:0] CHK_LOW  = 2'd3;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: reset-to-0 flop chain bringing an asynchronous bit into clk
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] r;
   always_ff @(posedge clk or negedge rst)
      if (!rst) r <= '0;
      else      r <= {r[STAGES-2:0], d};
   assign q = r[STAGES-1];
endmodule

// File: rtl/sync_debounce.sv
// sync_debounce: synchronise, debounce and edge-detect an asynchronous input
module sync_debounce
   import sync_debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   input  logic en,
   input  logic clear,
   output logic out,
   output logic rise,
   output logic fall
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   logic             s, hi, diff, last, rise_nx, fall_nx;
   logic [1:0]       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   sync_chain #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(din), .q(s));
   // state[1] is the settled level, so it doubles as the registered output
   assign hi   = state[1];
   assign out  = hi;
   assign diff = s ^ hi;
   // from a settled state cnt is 0, so last here means a single-sample debounce
   assign last = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      rise_nx  = 1'b0;
      fall_nx  = 1'b0;
      if (clear) begin
         state_nx = LOW;
         cnt_nx   = '0;
      end else if (en && !diff) begin
         state_nx = hi ? HIGH : LOW;
         cnt_nx   = '0;
      end else if (en && last) begin
         state_nx = hi ? LOW : HIGH;
         cnt_nx   = '0;
         rise_nx  = !hi;
         fall_nx  = hi;
      end else if (en) begin
         state_nx = hi ? CHK_LOW : CHK_HIGH;
         cnt_nx   = cnt + CNT_W'(1);
      end
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= LOW;
         cnt   <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         rise  <= rise_nx;
         fall  <= fall_nx;
      end
endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce: directed vector table plus randomized run against a sample-history model
module tb_sync_debounce;
   import sync_debounce_pkg::*;
   localparam int SS = 2;
   localparam int DC = 4;

   logic clk = 0, rst = 0, din = 0, en = 0, clear = 0;
   logic out, rise, fall;

   sync_debounce #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
      .clk(clk), .rst(rst), .din(din), .en(en), .clear(clear),
      .out(out), .rise(rise), .fall(fall)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // reference: din delayed by SS edges; out flips once DC consecutive enabled samples disagree with it
   logic dq[$];
   logic hist[$];
   logic m_out, m_rise, m_fall;

   task automatic model_reset();
      dq.delete();
      for (int i = 0; i < SS; i++) dq.push_back(1'b0);
      hist.delete();
      m_out = 0; m_rise = 0; m_fall = 0;
   endtask

   task automatic model_edge(input logic d, input logic e, input logic c);
      logic s;
      bit all_diff;
      s = dq.pop_front();
      dq.push_back(d);
      m_rise = 0; m_fall = 0;
      if (c) begin
         hist.delete();
         m_out = 0;
      end else if (e) begin
         hist.push_back(s);
         if (hist.size() > DC) void'(hist.pop_front());
         all_diff = hist.size() == DC;
         foreach (hist[k]) if (hist[k] == m_out) all_diff = 0;
         if (all_diff) begin
            m_out = ~m_out;
            m_rise = m_out;
            m_fall = !m_out;
            hist.delete();
         end
      end
   endtask

   task automatic step(input logic d, input logic e, input logic c);
      @(negedge clk);
      din = d; en = e; clear = c;
      @(posedge clk);
      model_edge(d, e, c);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 0; din = 0; en = 0; clear = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1;
   endtask

   typedef struct {
      logic d, e, c, o, r, f;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(input logic d, e, c, o, r, f, input int n);
      vec_t v;
      v.d = d; v.e = e; v.c = c; v.o = o; v.r = r; v.f = f;
      repeat (n) tbl.push_back(v);
   endfunction

   initial begin
      int hold;
      logic rd;
      model_reset();
      #1;
      check("reset_out", out, 0);
      check("reset_rise", rise, 0);
      check("reset_fall", fall, 0);
      @(negedge clk);
      rst = 1;

      // clean rise and fall, 6 edges each
      add(1,1,0, 0,0,0, 5); add(1,1,0, 1,1,0, 1); add(1,1,0, 1,0,0, 3);
      add(0,1,0, 1,0,0, 5); add(0,1,0, 0,0,1, 1); add(0,1,0, 0,0,0, 3);
      // 3-cycle high glitch from LOW
      add(1,1,0, 0,0,0, 3); add(0,1,0, 0,0,0, 5);
      // reach HIGH, then 3-cycle low glitch
      add(1,1,0, 0,0,0, 5); add(1,1,0, 1,1,0, 1); add(1,1,0, 1,0,0, 2);
      add(0,1,0, 1,0,0, 3); add(1,1,0, 1,0,0, 5);
      // clear in HIGH: no fall, re-rise 4 edges after clear drops
      add(1,1,1, 0,0,0, 1); add(1,1,0, 0,0,0, 3); add(1,1,0, 1,1,0, 1); add(1,1,0, 1,0,0, 1);
      foreach (tbl[i]) begin
         step(tbl[i].d, tbl[i].e, tbl[i].c);
         check($sformatf("vec%0d_out", i), out, tbl[i].o);
         check($sformatf("vec%0d_rise", i), rise, tbl[i].r);
         check($sformatf("vec%0d_fall", i), fall, tbl[i].f);
      end

      // en gating: 5 disabled cycles inside CHK_HIGH push the rise to edge 11
      do_reset();
      for (int k = 1; k <= 11; k++) begin
         step(1, !(k >= 4 && k <= 8), 0);
         if (k >= 4 && k <= 8) check($sformatf("engate_cnt%0d", k), int'(dut.cnt), 1);
         check($sformatf("engate_out%0d", k), out, k == 11);
         check($sformatf("engate_rise%0d", k), rise, k == 11);
      end

      // clear on the edge that would complete the debounce
      do_reset();
      repeat (5) step(1, 1, 0);
      check("simclr_pre_out", out, 0);
      step(1, 1, 1);
      check("simclr_out", out, 0);
      check("simclr_rise", rise, 0);
      check("simclr_state", int'(dut.state), int'(LOW));
      for (int k = 1; k <= 4; k++) begin
         step(1, 1, 0);
         check($sformatf("simclr_rerise_out%0d", k), out, k == 4);
         check($sformatf("simclr_rerise_rise%0d", k), rise, k == 4);
      end

      // async reset between edges, right after a rise
      do_reset();
      repeat (6) step(1, 1, 0);
      check("async_pre_out", out, 1);
      check("async_pre_rise", rise, 1);
      #1 rst = 0; din = 0;
      #1;
      check("async_out", out, 0);
      check("async_rise", rise, 0);
      check("async_fall", fall, 0);
      model_reset();
      @(negedge clk) rst = 1;
      for (int k = 0; k < 8; k++) begin
         step(0, 1, 0);
         check($sformatf("async_post_out%0d", k), out, 0);
      end

      // randomized run against the model
      hold = 0; rd = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 700 == 699) do_reset();
         if (hold == 0) begin
            rd = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 8);
         end
         hold--;
         step(rd, $urandom_range(0, 7) != 0, $urandom_range(0, 63) == 0);
         check($sformatf("rnd%0d_out", i), out, m_out);
         check($sformatf("rnd%0d_rise", i), rise, m_rise);
         check($sformatf("rnd%0d_fall", i), fall, m_fall);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
